// File: rtl/codec_cfg_seq.sv
// Codec configuration sequencer: after a power-up wait, writes an 8-entry register
// table to the codec through an I2C master, with per-entry retry, timeout and restart.
module codec_cfg_seq #(
    parameter logic [6:0]  DEV_ADDR = 7'h1A,
    parameter int unsigned PWR_WAIT = 1024,
    parameter int unsigned GAP      = 16,
    parameter int unsigned TIMEOUT  = 4096,
    parameter int unsigned MAX_TRY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    output logic        i2c_start,
    output logic [6:0]  i2c_dev,
    output logic [15:0] i2c_word,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        codec_en,
    output logic        cfg_busy,
    output logic        cfg_err,
    output logic [2:0]  err_idx
);
    // state | meaning
    // PWR   | power-up settle, counting PWR_WAIT cycles before the first write
    // ISSUE | one-cycle write request for table[idx]
    // WAIT  | waiting for i2c_done or the timeout
    // GAP   | idle spacing before the next (or repeated) write
    // DONE  | table written, serial audio interface enabled
    // ERROR | an entry failed MAX_TRY times, err_idx names it

    localparam int unsigned CNT_MAX = (PWR_WAIT > GAP)
        ? ((PWR_WAIT > TIMEOUT) ? PWR_WAIT : TIMEOUT)
        : ((GAP > TIMEOUT) ? GAP : TIMEOUT);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int TRY_W = $clog2(MAX_TRY + 1);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_WAIT);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRY);

    typedef enum logic [2:0] {
        S_PWR,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    function automatic logic [15:0] cfg_word(input logic [2:0] i);
        case (i)
            3'd0:    cfg_word = 16'h1E00;
            3'd1:    cfg_word = 16'h0C00;
            3'd2:    cfg_word = 16'h0812;
            3'd3:    cfg_word = 16'h0A00;
            3'd4:    cfg_word = 16'h0E01;
            3'd5:    cfg_word = 16'h1000;
            3'd6:    cfg_word = 16'h0017;
            default: cfg_word = 16'h1201;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [TRY_W-1:0]  try_q, try_d;
    logic [2:0]        err_idx_q, err_idx_d;
    logic [15:0]       word_q, word_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic [TRY_W-1:0]  try_inc;
    logic              attempt_ok;
    logic              attempt_fail;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign try_inc = try_q + TRY_W'(1);

    // A done pulse decides the attempt; the timeout only counts when no done arrives.
    assign attempt_ok   = i2c_done && !i2c_nack;
    assign attempt_fail = i2c_done ? i2c_nack : (cnt_inc == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_PWR;
            cnt_q     <= '0;
            idx_q     <= '0;
            try_q     <= '0;
            err_idx_q <= '0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            try_q     <= try_d;
            err_idx_q <= err_idx_d;
            word_q    <= word_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        try_d     = try_q;
        err_idx_d = err_idx_q;
        word_d    = word_q;

        case (state_q)
            S_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    try_d   = '0;
                    word_d  = cfg_word(3'd0);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (attempt_ok) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        try_d   = '0;
                        state_d = S_GAP;
                    end
                end else if (attempt_fail) begin
                    cnt_d = '0;
                    try_d = try_inc;
                    if (try_inc == TRY_LAST) begin
                        state_d   = S_ERROR;
                        err_idx_d = idx_q;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                    word_d  = cfg_word(idx_q);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_d   = S_PWR;
                    cnt_d     = '0;
                    idx_d     = '0;
                    try_d     = '0;
                    err_idx_d = '0;
                    word_d    = '0;
                end
            end
            default: state_d = S_PWR;
        endcase
    end

    assign i2c_start = (state_q == S_ISSUE);
    assign i2c_dev   = DEV_ADDR;
    assign i2c_word  = word_q;
    assign codec_en  = (state_q == S_DONE);
    assign cfg_busy  = (state_q != S_DONE) && (state_q != S_ERROR);
    assign cfg_err   = (state_q == S_ERROR);
    assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Bench for codec_cfg_seq: event-level reference model checked every cycle, plus
// directed scenarios with hand-computed timing and word expectations.
module tb_codec_cfg_seq;
    localparam int PWR_WAIT = 1024;
    localparam int GAP      = 16;
    localparam int TIMEOUT  = 4096;
    localparam int MAX_TRY  = 3;

    localparam int M_RUN = 0, M_DONE = 1, M_ERR = 2;
    localparam int P_NONE = 0, P_ONCE = 1, P_ALWAYS = 2, P_HOLD = 3, P_RAND = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        i2c_start;
    logic [6:0]  i2c_dev;
    logic [15:0] i2c_word;
    logic        codec_en;
    logic        cfg_busy;
    logic        cfg_err;
    logic [2:0]  err_idx;

    codec_cfg_seq dut (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .i2c_start(i2c_start),
        .i2c_dev  (i2c_dev),
        .i2c_word (i2c_word),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack),
        .codec_en (codec_en),
        .cfg_busy (cfg_busy),
        .cfg_err  (cfg_err),
        .err_idx  (err_idx)
    );

    always #10 clk = ~clk;

    logic [15:0] tbl [8] = '{16'h1E00, 16'h0C00, 16'h0812, 16'h0A00,
                             16'h0E01, 16'h1000, 16'h0017, 16'h1201};

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks only sequence position, attempt count and cycle
    // distances to the next write, reacting to the actual inputs each cycle.
    bit          m_valid = 0;
    int          m_mode, m_until, m_idx, m_try, m_waited, m_err;
    bit          m_infl;
    logic [15:0] m_word;
    bit          exp_start;

    task automatic model_clear();
        m_mode   = M_RUN;
        m_until  = PWR_WAIT + 1;
        m_idx    = 0;
        m_try    = 0;
        m_waited = 0;
        m_infl   = 0;
        m_word   = 16'h0000;
    endtask

    task automatic model_step();
        if (rst) begin
            model_clear();
            m_err   = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (m_mode == M_RUN) begin
                if (!m_infl) begin
                    if (m_until == 0) begin
                        m_infl   = 1;
                        m_waited = 0;
                    end else begin
                        m_until--;
                    end
                end else begin
                    m_waited++;
                    if (i2c_done && !i2c_nack) begin
                        m_infl = 0;
                        if (m_idx == 7) m_mode = M_DONE;
                        else begin
                            m_idx++;
                            m_try   = 0;
                            m_until = GAP + 1;
                        end
                    end else if (i2c_done || m_waited == TIMEOUT) begin
                        m_infl = 0;
                        m_try++;
                        if (m_try == MAX_TRY) begin
                            m_mode = M_ERR;
                            m_err  = m_idx;
                        end else begin
                            m_until = GAP + 1;
                        end
                    end
                end
            end else if (restart) begin
                model_clear();
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp_start = (m_mode == M_RUN) && !m_infl && (m_until == 0);
                if (exp_start) m_word = tbl[m_idx];
                chk("i2c_start", 32'(i2c_start), 32'(exp_start));
                chk("i2c_word", 32'(i2c_word), 32'(m_word));
                chk("codec_en", 32'(codec_en), 32'(m_mode == M_DONE));
                chk("cfg_busy", 32'(cfg_busy), 32'(m_mode == M_RUN));
                chk("cfg_err", 32'(cfg_err), 32'(m_mode == M_ERR));
                chk("i2c_dev", 32'(i2c_dev), 32'h1A);
                if (m_mode == M_ERR) chk("err_idx", 32'(err_idx), 32'(m_err));
            end
            model_step();
        end
    end

    // I2C master stand-in and start log
    int          pol = P_NONE;
    logic [15:0] pol_word = 16'h0000;
    int          pol_delay = 200;
    bit          noise = 0;
    bit          pend = 0;
    bit          pend_nack = 0;
    int          done_at = 0;
    int          last_done_cyc = -1000000;
    int          base = 0;
    logic [15:0] wlog[$];
    int          tlog[$];
    int          llog[$];

    function automatic int cnt_word(input logic [15:0] w);
        int n = 0;
        foreach (wlog[i]) if (wlog[i] == w) n++;
        return n;
    endfunction

    function automatic logic [15:0] wl(input int i);
        if (i < wlog.size()) return wlog[i];
        return 16'hxxxx;
    endfunction

    function automatic int tl(input int i);
        if (i < tlog.size()) return tlog[i];
        return -100000;
    endfunction

    function automatic int ll(input int i);
        if (i < llog.size()) return llog[i];
        return -100000;
    endfunction

    task automatic give(input int d, input bit nk);
        pend      = 1;
        done_at   = cyc + d;
        pend_nack = nk;
    endtask

    task automatic respond();
        int a;
        wlog.push_back(i2c_word);
        tlog.push_back(cyc);
        llog.push_back(cyc - last_done_cyc);
        a = cnt_word(i2c_word);
        if (pol == P_ONCE) give(pol_delay, i2c_word == pol_word && a == 1);
        else if (pol == P_ALWAYS) give(pol_delay, i2c_word == pol_word);
        else if (pol == P_HOLD) begin
            if (i2c_word != pol_word) give(pol_delay, 1'b0);
            else pend = 0;
        end else if (pol == P_RAND) begin
            if ($urandom_range(49) != 0) give(int'($urandom_range(300, 1)), $urandom_range(4) == 0);
            else pend = 0;
        end else give(pol_delay, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        restart  = 1'b0;
        if (pend && cyc >= done_at) begin
            i2c_done      = 1'b1;
            i2c_nack      = pend_nack;
            pend          = 0;
            last_done_cyc = cyc;
        end
        if (noise && !i2c_done && $urandom_range(99) == 0) begin
            i2c_done = 1'b1;
            i2c_nack = 1'($urandom_range(1));
        end
        if (noise && cfg_busy && $urandom_range(199) == 0) restart = 1'b1;
        if (i2c_start === 1'b1) respond();
    endtask

    task automatic clear_log();
        wlog.delete();
        tlog.delete();
        llog.delete();
    endtask

    task automatic wait_end(input int bound, input string name);
        int n = 0;
        while (!(codec_en === 1'b1 || cfg_err === 1'b1) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no DONE/ERROR within %0d cycles", name, bound);
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        base = cyc;
        clear_log();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst  = 1'b0;
        base = cyc;
        chk("rst_start", 32'(i2c_start), 32'd0);
        chk("rst_word", 32'(i2c_word), 32'h0000);
        chk("rst_codec_en", 32'(codec_en), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd1);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_err_idx", 32'(err_idx), 32'd0);

        // nominal: every write ACKed 200 cycles after its start
        pol = P_NONE; pol_delay = 200;
        clear_log();
        wait_end(6000, "nom_end");
        chk("nom_first_start", 32'(tl(0) - base), 32'd1025);
        chk("nom_starts", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("nom_word", 32'(wl(i)), 32'(tbl[i]));
        chk("nom_done_to_start", 32'(ll(1)), 32'd18);
        chk("nom_codec_en", 32'(codec_en), 32'd1);
        chk("nom_busy", 32'(cfg_busy), 32'd0);

        // single NACK on entry 3
        pol = P_ONCE; pol_word = 16'h0A00;
        do_restart();
        chk("restart_codec_en", 32'(codec_en), 32'd0);
        chk("restart_busy", 32'(cfg_busy), 32'd1);
        wait_end(6000, "nack1_end");
        chk("nack1_reissue_word", 32'(wl(4)), 32'h0A00);
        chk("nack1_reissue_lat", 32'(ll(4)), 32'd18);
        chk("nack1_starts", 32'(wlog.size()), 32'd9);
        chk("nack1_codec_en", 32'(codec_en), 32'd1);
        chk("nack1_err", 32'(cfg_err), 32'd0);

        // persistent NACK on entry 5
        pol = P_ALWAYS; pol_word = 16'h1000;
        do_restart();
        wait_end(6000, "nackp_end");
        repeat (300) tick();
        chk("nackp_1000_starts", 32'(cnt_word(16'h1000)), 32'd3);
        chk("nackp_total_starts", 32'(wlog.size()), 32'd8);
        chk("nackp_err", 32'(cfg_err), 32'd1);
        chk("nackp_err_idx", 32'(err_idx), 32'd5);
        chk("nackp_codec_en", 32'(codec_en), 32'd0);

        // restart from ERROR, then withhold done on entry 0
        pol = P_HOLD; pol_word = 16'h1E00;
        do_restart();
        chk("err_restart_codec_en", 32'(codec_en), 32'd0);
        chk("err_restart_err", 32'(cfg_err), 32'd0);
        wait_end(20000, "tmo_end");
        chk("tmo_first_word", 32'(wl(0)), 32'h1E00);
        chk("tmo_first_start", 32'(tl(0) - base), 32'd1025);
        chk("tmo_starts", 32'(cnt_word(16'h1E00)), 32'd3);
        chk("tmo_retry1", 32'(tl(1) - tl(0)), 32'd4114);
        chk("tmo_retry2", 32'(tl(2) - tl(1)), 32'd4114);
        chk("tmo_err", 32'(cfg_err), 32'd1);
        chk("tmo_err_idx", 32'(err_idx), 32'd0);

        // full rerun after ERROR
        pol = P_NONE; pol_delay = 50;
        do_restart();
        wait_end(6000, "rerun_end");
        chk("rerun_first_word", 32'(wl(0)), 32'h1E00);
        chk("rerun_starts", 32'(wlog.size()), 32'd8);
        chk("rerun_codec_en", 32'(codec_en), 32'd1);

        // reset while waiting on entry 4; its done lands during PWR
        pol = P_NONE; pol_delay = 200;
        do_restart();
        for (int n = 0; n < 4000 && wlog.size() < 5; n++) tick();
        chk("rstw_word4", 32'(wl(4)), 32'h0E01);
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        base = cyc;
        clear_log();
        chk("rstw_busy", 32'(cfg_busy), 32'd1);
        chk("rstw_start", 32'(i2c_start), 32'd0);
        chk("rstw_word", 32'(i2c_word), 32'h0000);
        wait_end(6000, "rstw_end");
        chk("rstw_first_start", 32'(tl(0) - base), 32'd1025);
        chk("rstw_first_word", 32'(wl(0)), 32'h1E00);
        chk("rstw_starts", 32'(wlog.size()), 32'd8);

        // randomized responses, stray done/restart pulses, restarts and resets
        pol   = P_RAND;
        noise = 1;
        for (int r = 0; r < 5; r++) begin
            if (r % 2 == 0) do_restart();
            else begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            wait_end(40000, "rand_end");
        end
        noise = 0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
